ra_64x72_bist: RTL and testbench

// - March-C- built-in self test initiator for the 64x72 2R1W array wrapper.
// - Drives the wrapper's rd0/rd1/wr0 request ports and checks returned read data on both read ports.
// - Sits beside the array wrapper and is muxed onto its ports in test mode. Reports pass/fail and the first failing location.

---
 rtl/ra_64x72_bist_pkg.sv | 63 ++++++
 rtl/ra_64x72_bist_if.sv | 30 +++
 rtl/ra_64x72_bist_chk.sv | 89 ++++++++
 rtl/ra_64x72_bist.sv | 182 ++++++++++++++++++
 tb/tb_ra_64x72_bist.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ra_64x72_bist_pkg.sv
// March-C- BIST for the 64x72 2R1W array wrapper.
// Shared widths, encodings and background pattern helpers.
package ra_64x72_bist_pkg;

  localparam int ADR_W = 6;
  localparam int DAT_W = 72;

  localparam logic [0:ADR_W-1] ADR_MAX = '1;
  localparam logic [0:DAT_W-1] PAT_COL = {36{2'b10}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5
  } elem_e;

  typedef enum logic [1:0] {
    BG_ZERO,
    BG_CHECK,
    BG_COL,
    BG_ROW
  } bg_e;

  typedef struct packed {
    logic             vld;
    logic [0:ADR_W-1] adr;
    logic [0:DAT_W-1] exp;
  } chk_t;

  // adr[ADR_W-1] is the address LSB, so row-based
  // patterns alternate on every row.
  function automatic logic [0:DAT_W-1] bg_pat(
    input bg_e              sel,
    input logic [0:ADR_W-1] adr
  );
    logic [0:DAT_W-1] row;
    logic [0:DAT_W-1] pat;
    row = {DAT_W{adr[ADR_W-1]}};
    unique case (sel)
      BG_ZERO:  pat = '0;
      BG_CHECK: pat = PAT_COL ^ row;
      BG_COL:   pat = PAT_COL;
      default:  pat = row;
    endcase
    return pat;
  endfunction

  // Elements whose read expects ~D
  function automatic logic rd_inv(input elem_e e);
    return (e == M2) || (e == M4);
  endfunction

  // Elements whose write stores ~D
  function automatic logic wr_inv(input elem_e e);
    return (e == M1) || (e == M3);
  endfunction

endpackage

// File: rtl/ra_64x72_bist_if.sv
// Array request/return bundle between BIST and wrapper.
// Master drives requests, slave returns read data.
interface ra_64x72_bist_if;
  import ra_64x72_bist_pkg::*;

  logic             rd_enb_0;
  logic [0:ADR_W-1] rd_adr_0;
  logic [0:DAT_W-1] rd_dat_0;
  logic             rd_enb_1;
  logic [0:ADR_W-1] rd_adr_1;
  logic [0:DAT_W-1] rd_dat_1;
  logic             wr_enb_0;
  logic [0:ADR_W-1] wr_adr_0;
  logic [0:DAT_W-1] wr_dat_0;

  modport master (
    output rd_enb_0, rd_adr_0,
    output rd_enb_1, rd_adr_1,
    output wr_enb_0, wr_adr_0, wr_dat_0,
    input  rd_dat_0, rd_dat_1
  );

  modport slave (
    input  rd_enb_0, rd_adr_0,
    input  rd_enb_1, rd_adr_1,
    input  wr_enb_0, wr_adr_0, wr_dat_0,
    output rd_dat_0, rd_dat_1
  );

endinterface

// File: rtl/ra_64x72_bist_chk.sv
// Read-data checker: expected/valid delay pipe, dual
// 72-bit compare, first-fail capture, saturating count.
module ra_64x72_bist_chk
  import ra_64x72_bist_pkg::*;
#(
  parameter int RDLAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [0:ADR_W-1] adr_i,
  input  logic [0:DAT_W-1] exp_i,
  input  logic [0:DAT_W-1] dat0_i,
  input  logic [0:DAT_W-1] dat1_i,
  output logic             fail_o,
  output logic [0:ADR_W-1] fail_adr_o,
  output logic             fail_port_o,
  output logic [7:0]       fail_cnt_o
);

  chk_t             pipe_q [RDLAT];
  chk_t             cur;
  logic             mis0;
  logic             mis1;
  logic [8:0]       sum;
  logic             fail_q, fail_d;
  logic [0:ADR_W-1] fadr_q, fadr_d;
  logic             fprt_q, fprt_d;
  logic [7:0]       cnt_q, cnt_d;

  // Delay expected data so it lines up with read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RDLAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {vld_i, adr_i, exp_i};
      for (int i = 1; i < RDLAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Compare both ports and update fail status
  always_comb begin
    cur    = pipe_q[RDLAT-1];
    mis0   = cur.vld && (dat0_i != cur.exp);
    mis1   = cur.vld && (dat1_i != cur.exp);
    sum    = {1'b0, cnt_q} + {8'd0, mis0}
           + {8'd0, mis1};
    fail_d = fail_q;
    fadr_d = fadr_q;
    fprt_d = fprt_q;
    cnt_d  = sum[8] ? 8'hFF : sum[7:0];
    if (clr_i) begin
      fail_d = 1'b0;
      fadr_d = '0;
      fprt_d = 1'b0;
      cnt_d  = '0;
    end else if (mis0 || mis1) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fadr_d = cur.adr;
        fprt_d = !mis0;
      end
    end
  end

  // Fail status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_q <= 1'b0;
      fadr_q <= '0;
      fprt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fail_q <= fail_d;
      fadr_q <= fadr_d;
      fprt_q <= fprt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_adr_o  = fadr_q;
  assign fail_port_o = fprt_q;
  assign fail_cnt_o  = cnt_q;

endmodule

// File: rtl/ra_64x72_bist.sv
// March-C- BIST top: FSM, element/address sequencer,
// pattern generator and registered array requests.
module ra_64x72_bist
  import ra_64x72_bist_pkg::*;
#(
  // 1 = wrapper LATCHRD=0, 2 = wrapper LATCHRD=1
  parameter int RDLAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       bg_sel,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [0:ADR_W-1] fail_adr,
  output logic             fail_port,
  output logic [7:0]       fail_cnt,
  ra_64x72_bist_if.master  ary
);

  state_e           st_q, st_d;
  elem_e            elem_q, elem_d;
  logic [0:ADR_W-1] adr_q, adr_d;
  logic             ph_q, ph_d;
  logic [1:0]       drn_q, drn_d;
  bg_e              bg_q, bg_d;
  logic             issue;
  logic             clr;
  logic             last;
  logic [0:DAT_W-1] pat_d;
  logic [0:DAT_W-1] wdat_d;
  logic [0:DAT_W-1] exp_d;
  logic             rd_enb_q;
  logic             wr_enb_q;
  logic [0:DAT_W-1] wdat_q;
  logic [0:DAT_W-1] exp_q;

  // Sequencer state: counters always describe the op
  // currently presented on the request ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= S_IDLE;
      elem_q <= M0;
      adr_q  <= '0;
      ph_q   <= 1'b0;
      drn_q  <= '0;
      bg_q   <= BG_ZERO;
    end else begin
      st_q   <= st_d;
      elem_q <= elem_d;
      adr_q  <= adr_d;
      ph_q   <= ph_d;
      drn_q  <= drn_d;
      bg_q   <= bg_d;
    end
  end

  // Next state and next op; ph=0 read, ph=1 write
  always_comb begin
    st_d   = st_q;
    elem_d = elem_q;
    adr_d  = adr_q;
    ph_d   = ph_q;
    drn_d  = drn_q;
    bg_d   = bg_q;
    issue  = 1'b0;
    clr    = 1'b0;
    last   = (elem_q == M5) && (adr_q == '0);
    unique case (st_q)
      S_RUN: begin
        if (last) begin
          st_d  = S_DRAIN;
          drn_d = '0;
        end else begin
          issue = 1'b1;
          unique case (elem_q)
            M0: begin
              if (adr_q == ADR_MAX) begin
                elem_d = M1;
                adr_d  = '0;
                ph_d   = 1'b0;
              end else begin
                adr_d = adr_q + ADR_W'(1);
              end
            end
            M1, M2: begin
              ph_d = !ph_q;
              if (ph_q) begin
                if (adr_q == ADR_MAX) begin
                  elem_d = elem_e'(elem_q + 3'd1);
                  adr_d  = (elem_q == M2) ? ADR_MAX : '0;
                end else begin
                  adr_d = adr_q + ADR_W'(1);
                end
              end
            end
            M3, M4: begin
              ph_d = !ph_q;
              if (ph_q) begin
                if (adr_q == '0) begin
                  elem_d = elem_e'(elem_q + 3'd1);
                  adr_d  = ADR_MAX;
                end else begin
                  adr_d = adr_q - ADR_W'(1);
                end
              end
            end
            default: begin
              adr_d = adr_q - ADR_W'(1);
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (drn_q == 2'(RDLAT - 1)) begin
          st_d = S_DONE;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      default: begin
        if (start) begin
          st_d   = S_RUN;
          elem_d = M0;
          adr_d  = '0;
          ph_d   = 1'b1;
          bg_d   = bg_e'(bg_sel);
          issue  = 1'b1;
          clr    = 1'b1;
        end
      end
    endcase
    pat_d  = bg_pat(bg_d, adr_d);
    wdat_d = pat_d ^ {DAT_W{wr_inv(elem_d)}};
    exp_d  = pat_d ^ {DAT_W{rd_inv(elem_d)}};
  end

  // Registered request enables and data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_enb_q <= 1'b0;
      wr_enb_q <= 1'b0;
      wdat_q   <= '0;
      exp_q    <= '0;
    end else begin
      rd_enb_q <= issue && !ph_d;
      wr_enb_q <= issue && ph_d;
      if (issue && ph_d) wdat_q <= wdat_d;
      if (issue && !ph_d) exp_q <= exp_d;
    end
  end

  assign ary.rd_enb_0 = rd_enb_q;
  assign ary.rd_enb_1 = rd_enb_q;
  assign ary.rd_adr_0 = adr_q;
  assign ary.rd_adr_1 = adr_q;
  assign ary.wr_enb_0 = wr_enb_q;
  assign ary.wr_adr_0 = adr_q;
  assign ary.wr_dat_0 = wdat_q;

  assign busy = (st_q == S_RUN) || (st_q == S_DRAIN);
  assign done = (st_q == S_DONE);

  ra_64x72_bist_chk #(
    .RDLAT (RDLAT)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (clr),
    .vld_i       (rd_enb_q),
    .adr_i       (adr_q),
    .exp_i       (exp_q),
    .dat0_i      (ary.rd_dat_0),
    .dat1_i      (ary.rd_dat_1),
    .fail_o      (fail),
    .fail_adr_o  (fail_adr),
    .fail_port_o (fail_port),
    .fail_cnt_o  (fail_cnt)
  );

endmodule

// File: tb/tb_ra_64x72_bist.sv
// Directed bench for ra_64x72_bist: two instances
// (RDLAT 1 and 2) run against behavioural array models.
module tb_ra_64x72_bist;

  localparam logic [0:71] AA = {36{2'b10}};
  localparam logic [0:71] P55 = {36{2'b01}};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] bg_sel;
  int         fault;
  int         vecs = 0;
  int         errs = 0;

  logic       busy [2];
  logic       done [2];
  logic       fail [2];
  logic [0:5] fail_adr [2];
  logic       fail_port [2];
  logic [7:0] fail_cnt [2];

  logic        re0 [2];
  logic        re1 [2];
  logic        we [2];
  logic [0:5]  ra0 [2];
  logic [0:5]  ra1 [2];
  logic [0:71] wd [2];

  int          done_at [2];
  int          iss [2];
  int          bad [2];
  logic [0:71] w1 [2];
  logic [0:71] w2 [2];
  logic [0:71] w66 [2];
  logic        r65 [2];
  logic        b1 [2];
  logic        d1 [2];

  logic [0:71] mem0 [64];
  logic [0:71] mem1 [64];
  logic [0:71] s0_1;
  logic [0:71] s1_1;

  always #5 clk = ~clk;

  ra_64x72_bist_if ifc0 ();
  ra_64x72_bist_if ifc1 ();

  ra_64x72_bist #(.RDLAT(1)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bg_sel    (bg_sel),
    .busy      (busy[0]),
    .done      (done[0]),
    .fail      (fail[0]),
    .fail_adr  (fail_adr[0]),
    .fail_port (fail_port[0]),
    .fail_cnt  (fail_cnt[0]),
    .ary       (ifc0)
  );

  ra_64x72_bist #(.RDLAT(2)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bg_sel    (bg_sel),
    .busy      (busy[1]),
    .done      (done[1]),
    .fail      (fail[1]),
    .fail_adr  (fail_adr[1]),
    .fail_port (fail_port[1]),
    .fail_cnt  (fail_cnt[1]),
    .ary       (ifc1)
  );

  assign re0[0] = ifc0.rd_enb_0;
  assign re1[0] = ifc0.rd_enb_1;
  assign we[0]  = ifc0.wr_enb_0;
  assign ra0[0] = ifc0.rd_adr_0;
  assign ra1[0] = ifc0.rd_adr_1;
  assign wd[0]  = ifc0.wr_dat_0;
  assign re0[1] = ifc1.rd_enb_0;
  assign re1[1] = ifc1.rd_enb_1;
  assign we[1]  = ifc1.wr_enb_0;
  assign ra0[1] = ifc1.rd_adr_0;
  assign ra1[1] = ifc1.rd_adr_1;
  assign wd[1]  = ifc1.wr_dat_0;

  // Read-side faults: 1 = bit 17 of 0x2A stuck-1 on
  // port 0; 3 = every bit of both ports stuck-1
  function automatic logic [0:71] rd_flt(
    input logic [0:71] d,
    input logic [0:5]  a,
    input int          port
  );
    logic [0:71] r;
    r = d;
    if (fault == 1 && a == 6'h2A && port == 0) r[17] = 1'b1;
    if (fault == 3) r = '1;
    return r;
  endfunction

  // Array model, latency 1; fault 2 aliases adr 5 onto 6
  always @(posedge clk) begin
    if (ifc0.wr_enb_0) begin
      mem0[ifc0.wr_adr_0] <= ifc0.wr_dat_0;
      if (fault == 2 && ifc0.wr_adr_0 == 6'd5)
        mem0[6] <= ifc0.wr_dat_0;
    end
    if (ifc0.rd_enb_0)
      ifc0.rd_dat_0 <= rd_flt(mem0[ifc0.rd_adr_0],
                              ifc0.rd_adr_0, 0);
    if (ifc0.rd_enb_1)
      ifc0.rd_dat_1 <= rd_flt(mem0[ifc0.rd_adr_1],
                              ifc0.rd_adr_1, 1);
  end

  // Array model, latency 2
  always @(posedge clk) begin
    if (ifc1.wr_enb_0) begin
      mem1[ifc1.wr_adr_0] <= ifc1.wr_dat_0;
      if (fault == 2 && ifc1.wr_adr_0 == 6'd5)
        mem1[6] <= ifc1.wr_dat_0;
    end
    if (ifc1.rd_enb_0)
      s0_1 <= rd_flt(mem1[ifc1.rd_adr_0], ifc1.rd_adr_0, 0);
    if (ifc1.rd_enb_1)
      s1_1 <= rd_flt(mem1[ifc1.rd_adr_1], ifc1.rd_adr_1, 1);
    ifc1.rd_dat_0 <= s0_1;
    ifc1.rd_dat_1 <= s1_1;
  end

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle t, then observe cycles t+1..t+645
  task automatic run(input logic [1:0] bg,
                     input int flt,
                     input int pulse_n);
    fault  = flt;
    bg_sel = bg;
    start  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      done_at[k] = 0;
      iss[k] = 0;
      bad[k] = 0;
    end
    for (int n = 1; n <= 645; n++) begin
      step();
      start = (n == pulse_n);
      for (int k = 0; k < 2; k++) begin
        if (re0[k] || we[k]) iss[k]++;
        if (re0[k] != re1[k] || (re0[k] && we[k]))
          bad[k]++;
        if (re0[k] && ra0[k] != ra1[k]) bad[k]++;
        if (done[k] && done_at[k] == 0) done_at[k] = n;
        if (n == 1) begin
          w1[k] = wd[k];
          b1[k] = busy[k];
          d1[k] = done[k];
        end
        if (n == 2) w2[k] = wd[k];
        if (n == 66) w66[k] = wd[k];
        if (n == 65)
          r65[k] = re0[k] && !we[k] && ra0[k] == 6'd0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy_t1[%0d]", k), b1[k], 1'b1);
      chk($sformatf("done_clr[%0d]", k), d1[k], 1'b0);
      chk($sformatf("issue_cnt[%0d]", k), iss[k], 640);
      chk($sformatf("port_rule[%0d]", k), bad[k], 0);
      chk($sformatf("m1_rd0[%0d]", k), r65[k], 1'b1);
      chk($sformatf("done_at[%0d]", k),
          done_at[k], 642 + k);
      chk($sformatf("busy_end[%0d]", k), busy[k], 1'b0);
    end
  endtask

  task automatic res(input string tag,
                     input logic f,
                     input logic [5:0] a,
                     input logic p,
                     input logic [7:0] c);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_fail[%0d]", tag, k), fail[k], f);
      chk($sformatf("%s_cnt[%0d]", tag, k), fail_cnt[k], c);
      if (f) begin
        chk($sformatf("%s_adr[%0d]", tag, k),
            fail_adr[k], a);
        chk($sformatf("%s_port[%0d]", tag, k),
            fail_port[k], p);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bg_sel  = 2'b00;
    fault   = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("rst_done[%0d]", k), done[k], 1'b0);
      chk($sformatf("rst_fail[%0d]", k), fail[k], 1'b0);
      chk($sformatf("rst_cnt[%0d]", k), fail_cnt[k], 8'd0);
      chk($sformatf("rst_adr[%0d]", k), fail_adr[k], 6'd0);
      chk($sformatf("rst_enb[%0d]", k),
          {re0[k], re1[k], we[k]}, 3'b000);
    end

    // Good array, all-0 background
    run(2'b00, 0, 0);
    res("good_bg0", 1'b0, 6'd0, 1'b0, 8'd0);
    for (int k = 0; k < 2; k++)
      chk($sformatf("bg0_wd[%0d]", k), w1[k], 72'd0);

    // Good array, checkerboard, started from DONE
    run(2'b01, 0, 0);
    res("good_bg1", 1'b0, 6'd0, 1'b0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ck_adr0[%0d]", k), w1[k], AA);
      chk($sformatf("ck_adr1[%0d]", k), w2[k], P55);
      chk($sformatf("ck_m1w0[%0d]", k), w66[k], P55);
    end

    // Column stripe and row stripe backgrounds
    run(2'b10, 0, 0);
    res("good_bg2", 1'b0, 6'd0, 1'b0, 8'd0);
    for (int k = 0; k < 2; k++)
      chk($sformatf("col_adr1[%0d]", k), w2[k], AA);
    run(2'b11, 0, 0);
    res("good_bg3", 1'b0, 6'd0, 1'b0, 8'd0);
    for (int k = 0; k < 2; k++)
      chk($sformatf("row_adr1[%0d]", k), w2[k], '1);

    // Single stuck bit on port 0
    run(2'b00, 1, 0);
    res("stuck17", 1'b1, 6'h2A, 1'b0, 8'd3);

    // Write to 5 also lands on 6
    run(2'b00, 2, 0);
    res("alias", 1'b1, 6'd6, 1'b0, 8'd4);

    // Start pulse mid-run must be ignored
    run(2'b00, 0, 200);
    res("pulse", 1'b0, 6'd0, 1'b0, 8'd0);

    // Reset in issue cycle 300 (an M2 write)
    fault  = 0;
    bg_sel = 2'b00;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int n = 2; n <= 300; n++) step();
    for (int k = 0; k < 2; k++)
      chk($sformatf("pre_rst_we[%0d]", k), we[k], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("async_enb[%0d]", k),
          {re0[k], re1[k], we[k]}, 3'b000);
    step();
    reset_n = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("post_done[%0d]", k), done[k], 1'b0);
      chk($sformatf("post_enb[%0d]", k),
          {re0[k], we[k]}, 2'b00);
    end
    run(2'b00, 0, 0);
    res("after_rst", 1'b0, 6'd0, 1'b0, 8'd0);

    // Everything stuck-1: count saturates
    run(2'b00, 3, 0);
    res("sat", 1'b1, 6'd0, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
